// File: rtl/tmr_pkg.sv
// Shared constants for the 8-bit timer counting core: bus register map,
// count-source codes, TCSR bit positions and register reset values.
package tmr_pkg;

   // CPU register map
   localparam logic [1:0] ADDR_TCNT  = 2'd0;
   localparam logic [1:0] ADDR_TCORA = 2'd1;
   localparam logic [1:0] ADDR_TCORB = 2'd2;
   localparam logic [1:0] ADDR_TCSR  = 2'd3;

   // CKS2..0 count-source codes
   localparam logic [2:0] CKS_STOP     = 3'b000;
   localparam logic [2:0] CKS_DIV_A    = 3'b001;
   localparam logic [2:0] CKS_DIV_B    = 3'b010;
   localparam logic [2:0] CKS_DIV_C    = 3'b011;
   localparam logic [2:0] CKS_CASCADE  = 3'b100;
   localparam logic [2:0] CKS_EXT_RISE = 3'b101;
   localparam logic [2:0] CKS_EXT_FALL = 3'b110;
   localparam logic [2:0] CKS_EXT_BOTH = 3'b111;

   // TCSR flag bit positions
   localparam int TCSR_CMFB = 7;
   localparam int TCSR_CMFA = 6;
   localparam int TCSR_OVF  = 5;

   // Register reset values
   localparam logic [7:0] TCNT_RST = 8'h00;
   localparam logic [7:0] TCOR_RST = 8'hFF;
   localparam logic [7:0] TCSR_RST = 8'h00;

   // External clock edge selection, encoded to match CKS[1:0] of codes 1xx
   typedef enum logic [1:0] {
      EDGE_NONE = 2'b00,
      EDGE_RISE = 2'b01,
      EDGE_FALL = 2'b10,
      EDGE_BOTH = 2'b11
   } edge_mode_e;

endpackage

// File: rtl/tmr_edge_sync.sv
// External clock pin conditioning: 2-flop synchronizer, previous-value flop
// and rise/fall/both edge selection. Produces a 1-cycle tick per selected edge.
import tmr_pkg::*;

module tmr_edge_sync (
   input  logic       clk,
   input  logic       rst,
   input  logic       tmci,
   input  edge_mode_e edge_mode,
   output logic       ext_tick
);

   logic sync_1;
   logic sync_2;
   logic prev;
   logic rise;
   logic fall;

   // Bring tmci into the clk domain and keep one sample of history
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_1 <= 1'b0;
         sync_2 <= 1'b0;
         prev   <= 1'b0;
      end else begin
         sync_1 <= tmci;
         sync_2 <= sync_1;
         prev   <= sync_2;
      end
   end

   // Edge detect and select which edges count
   always_comb begin
      rise     = sync_2 & ~prev;
      fall     = ~sync_2 & prev;
      ext_tick = 1'b0;
      case (edge_mode)
         EDGE_RISE: ext_tick = rise;
         EDGE_FALL: ext_tick = fall;
         EDGE_BOTH: ext_tick = rise | fall;
         default:   ext_tick = 1'b0;
      endcase
   end

endmodule

// File: rtl/tmr_count_unit.sv
// Single-channel 8-bit timer counting core: prescaler, count-source select,
// TCNT/TCORA/TCORB/TCSR, compare-match and overflow pulses.
// Build option: TMR_EXT_CLK_EN enables the tmci synchronizer and the
// external-edge count sources (CKS 101/110/111); otherwise those codes stop.
import tmr_pkg::*;

module tmr_count_unit #(
   parameter int BIT_WIDTH            = 8,
   parameter int CLK_SELECT_BIT_WIDTH = 5,
   parameter int PRESCALE_WIDTH       = 12
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [CLK_SELECT_BIT_WIDTH-1:0] clock_select,
   input  logic                            counter_clear,
   input  logic                            tmci,
   input  logic                            cascade_tick,
   input  logic                            bus_wr,
   input  logic                            bus_rd,
   input  logic [1:0]                      bus_addr,
   input  logic [BIT_WIDTH-1:0]            bus_wdata,
   output logic [BIT_WIDTH-1:0]            bus_rdata,
   output logic [BIT_WIDTH-1:0]            tcsr,
   output logic                            compare_match_a,
   output logic                            compare_match_b,
   output logic                            overflow
);

   logic [2:0]                cks;
   logic [1:0]                icks;
   logic [PRESCALE_WIDTH-1:0] prescaler;
   logic [PRESCALE_WIDTH-1:0] div_mask;
   logic                      div_sel;
   logic                      tick;
   logic                      ext_tick;

   logic [BIT_WIDTH-1:0]      tcnt;
   logic [BIT_WIDTH-1:0]      tcnt_next;
   logic [BIT_WIDTH-1:0]      tcora;
   logic [BIT_WIDTH-1:0]      tcorb;
   logic [4:0]                tcsr_ctrl;
   logic                      clear_pending;
   logic                      clear_pending_next;
   logic                      tcnt_updated;
   logic                      overflow_next;

   // flags/arms ordered {CMFB, CMFA, OVF} to line up with TCSR[7:5]
   logic [2:0]                flags;
   logic [2:0]                flag_arm;
   logic [2:0]                flag_set;

   logic                      wr_tcnt;
   logic                      wr_tcora;
   logic                      wr_tcorb;
   logic                      wr_tcsr;
   logic                      rd_tcsr;

   assign cks  = clock_select[CLK_SELECT_BIT_WIDTH-1 -: 3];
   assign icks = clock_select[1:0];

   assign wr_tcnt  = bus_wr && (bus_addr == ADDR_TCNT);
   assign wr_tcora = bus_wr && (bus_addr == ADDR_TCORA);
   assign wr_tcorb = bus_wr && (bus_addr == ADDR_TCORB);
   assign wr_tcsr  = bus_wr && (bus_addr == ADDR_TCSR);
   assign rd_tcsr  = bus_rd && (bus_addr == ADDR_TCSR);

`ifdef TMR_EXT_CLK_EN
   edge_mode_e edge_mode;
   assign edge_mode = cks[2] ? edge_mode_e'(cks[1:0]) : EDGE_NONE;

   tmr_edge_sync u_edge_sync (
      .clk       (clk),
      .rst       (rst),
      .tmci      (tmci),
      .edge_mode (edge_mode),
      .ext_tick  (ext_tick)
   );
`else
   // tmci is kept on the port but has no function in this build
   logic unused_tmci;
   assign unused_tmci = tmci;
   assign ext_tick    = 1'b0;
`endif

   // Free-running prescaler
   always_ff @(posedge clk or posedge rst) begin
      if (rst) prescaler <= '0;
      else     prescaler <= prescaler + PRESCALE_WIDTH'(1);
   end

   // Select the count source; internal ticks fire when the low N prescaler bits are all ones
   always_comb begin
      div_mask = '0;
      div_sel  = 1'b0;
      tick     = 1'b0;
      case (cks)
         CKS_DIV_A: begin
            div_mask = ~({PRESCALE_WIDTH{1'b1}} << (1 + int'(icks)));
            div_sel  = 1'b1;
         end
         CKS_DIV_B: begin
            div_mask = ~({PRESCALE_WIDTH{1'b1}} << (5 + int'(icks)));
            div_sel  = 1'b1;
         end
         CKS_DIV_C: begin
            div_mask = ~({PRESCALE_WIDTH{1'b1}} << (9 + int'(icks)));
            div_sel  = 1'b1;
         end
         CKS_CASCADE:  tick = cascade_tick;
         CKS_EXT_RISE,
         CKS_EXT_FALL,
         CKS_EXT_BOTH: tick = ext_tick;
         default:      tick = 1'b0;
      endcase
      if (div_sel) tick = ((prescaler & div_mask) == div_mask);
   end

   // Next TCNT: CPU write first, then a tick that either clears or increments
   always_comb begin
      tcnt_next          = tcnt;
      clear_pending_next = clear_pending;
      tcnt_updated       = 1'b0;
      overflow_next      = 1'b0;
      if (wr_tcnt) begin
         tcnt_next          = bus_wdata;
         clear_pending_next = 1'b0;
         tcnt_updated       = 1'b1;
      end else if (tick) begin
         tcnt_updated = 1'b1;
         if (clear_pending) begin
            tcnt_next          = '0;
            clear_pending_next = 1'b0;
         end else begin
            tcnt_next     = tcnt + BIT_WIDTH'(1);
            overflow_next = (tcnt == {BIT_WIDTH{1'b1}});
         end
      end
      // a clear request seen this cycle stays pending for the following tick
      if (counter_clear) clear_pending_next = 1'b1;
   end

   // Counter, pending clear and registered event pulses
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tcnt            <= BIT_WIDTH'(TCNT_RST);
         clear_pending   <= 1'b0;
         compare_match_a <= 1'b0;
         compare_match_b <= 1'b0;
         overflow        <= 1'b0;
      end else begin
         tcnt            <= tcnt_next;
         clear_pending   <= clear_pending_next;
         compare_match_a <= tcnt_updated && (tcnt_next == tcora);
         compare_match_b <= tcnt_updated && (tcnt_next == tcorb);
         overflow        <= overflow_next;
      end
   end

   // Compare registers and TCSR control bits
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tcora     <= BIT_WIDTH'(TCOR_RST);
         tcorb     <= BIT_WIDTH'(TCOR_RST);
         tcsr_ctrl <= TCSR_RST[4:0];
      end else begin
         if (wr_tcora) tcora     <= bus_wdata;
         if (wr_tcorb) tcorb     <= bus_wdata;
         if (wr_tcsr)  tcsr_ctrl <= bus_wdata[4:0];
      end
   end

   assign flag_set = {compare_match_b, compare_match_a, overflow};

   // Status flags: set wins over clear; clear needs a prior read of the flag as 1
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         flags    <= TCSR_RST[7:5];
         flag_arm <= 3'b000;
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (flag_set[i]) begin
               flags[i]    <= 1'b1;
               flag_arm[i] <= 1'b0;
            end else if (wr_tcsr && !bus_wdata[TCSR_OVF + i] && flag_arm[i]) begin
               flags[i]    <= 1'b0;
               flag_arm[i] <= 1'b0;
            end else if (rd_tcsr && flags[i]) begin
               flag_arm[i] <= 1'b1;
            end
         end
      end
   end

   assign tcsr = {flags, tcsr_ctrl};

   // Same-cycle read mux
   always_comb begin
      bus_rdata = tcnt;
      case (bus_addr)
         ADDR_TCNT:  bus_rdata = tcnt;
         ADDR_TCORA: bus_rdata = tcora;
         ADDR_TCORB: bus_rdata = tcorb;
         ADDR_TCSR:  bus_rdata = tcsr;
         default:    bus_rdata = tcnt;
      endcase
   end

endmodule
